// File: rtl/sm_status_monitor.sv
// Status monitor for a {o1,o2,err} upstream FSM: follows the status sequence,
// counts transactions and error episodes, flags dwell timeouts and raises irq.
module sm_status_monitor #(
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             o1,
    input  logic             o2,
    input  logic             err,
    input  logic             clr,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             tmo,
    output logic             irq,
    output logic [1:0]       mon_state
);

    typedef enum logic [1:0] {
        M_IDLE  = 2'b00,
        M_ARMED = 2'b01,
        M_BUSY  = 2'b10,
        M_ERR   = 2'b11
    } mstate_t;

    typedef enum logic [1:0] {C_IDLE, C_S1, C_S2, C_ERR} code_t;

    mstate_t          state;
    mstate_t          state_nxt;
    code_t            code;
    logic [TMO_W-1:0] dwell;
    logic [TMO_W-1:0] dwell_nxt;
    logic             done_ev;
    logic             err_ev;
    logic             active_nxt;
    logic             tmo_nxt;

    // Illegal upstream codes are treated exactly like the ERROR status.
    always_comb begin
        unique case ({o1, o2, err})
            3'b000:  code = C_IDLE;
            3'b100:  code = C_S1;
            3'b010:  code = C_S2;
            default: code = C_ERR;
        endcase
    end

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            M_IDLE: begin
                if (code == C_S1)       state_nxt = M_ARMED;
                else if (code == C_ERR) state_nxt = M_ERR;
            end
            M_ARMED: begin
                if (code == C_S2)        state_nxt = M_BUSY;
                else if (code == C_ERR)  state_nxt = M_ERR;
                else if (code == C_IDLE) state_nxt = M_IDLE;
            end
            M_BUSY: begin
                if (code == C_IDLE)                      state_nxt = M_IDLE;
                else if (code == C_ERR || code == C_S1)  state_nxt = M_ERR;
            end
            M_ERR: begin
                if (code == C_IDLE) state_nxt = M_IDLE;
            end
        endcase
    end

    assign done_ev    = (state == M_BUSY) && (code == C_IDLE);
    assign err_ev     = (state_nxt == M_ERR) && (state != M_ERR);
    assign active_nxt = (state_nxt == M_ARMED) || (state_nxt == M_BUSY);

    // Dwell restarts on every state change, so it counts edges spent in the current state.
    always_comb begin
        if (!active_nxt || state_nxt != state) dwell_nxt = '0;
        else if (dwell != '1)                  dwell_nxt = dwell + 1'b1;
        else                                   dwell_nxt = dwell;
    end

    assign tmo_nxt = active_nxt && (dwell_nxt >= TMO_W'(TMO_CYC));

    // Clear takes effect first, so an event on the clearing edge leaves a count of one.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                              input logic ev, input logic cl);
        logic [CNT_W-1:0] base;
        base = cl ? '0 : cnt;
        return (ev && base != '1) ? base + 1'b1 : base;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= M_IDLE;
            dwell      <= '0;
            done_cnt   <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            tmo        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_nxt;
            dwell      <= dwell_nxt;
            done_cnt   <= bump(done_cnt, done_ev, clr);
            err_cnt    <= bump(err_cnt, err_ev, clr);
            err_sticky <= err_ev | (err_sticky & ~clr);
            tmo        <= tmo_nxt;
            irq        <= err_ev | (tmo_nxt & ~tmo);
        end
    end

    assign mon_state = state;

endmodule

// File: tb/tb_sm_status_monitor.sv
// Bench for sm_status_monitor: directed scenarios plus randomized status runs,
// compared every cycle against a timestamp-based reference model.
module tb_sm_status_monitor;

    localparam int CNT_W   = 2;
    localparam int TMO_W   = 8;
    localparam int TMO_CYC = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             o1 = 1'b0;
    logic             o2 = 1'b0;
    logic             err = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic             tmo;
    logic             irq;
    logic [1:0]       mon_state;

    int total = 0;
    int bad   = 0;

    // Reference model: 0=idle 1=armed 2=busy 3=error; dwell tracked as cycle timestamps.
    int    m_state, m_done, m_err, m_sticky, m_tmo, m_irq;
    int    cyc, entered;
    string tag;

    sm_status_monitor #(.CNT_W(CNT_W), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .nrst(nrst), .o1(o1), .o2(o2), .err(err), .clr(clr),
        .done_cnt(done_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky),
        .tmo(tmo), .irq(irq), .mon_state(mon_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic check_all();
        check({tag, ":mon_state"},  32'(mon_state),  m_state);
        check({tag, ":done_cnt"},   32'(done_cnt),   m_done);
        check({tag, ":err_cnt"},    32'(err_cnt),    m_err);
        check({tag, ":err_sticky"}, 32'(err_sticky), m_sticky);
        check({tag, ":tmo"},        32'(tmo),        m_tmo);
        check({tag, ":irq"},        32'(irq),        m_irq);
    endtask

    task automatic model_reset();
        m_state = 0; m_done = 0; m_err = 0; m_sticky = 0; m_tmo = 0; m_irq = 0;
        entered = cyc;
    endtask

    function automatic int classify(input logic [2:0] c);
        case (c)
            3'b000:  return 0;
            3'b100:  return 1;
            3'b010:  return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step(input logic [2:0] c, input logic cl);
        int  k, nxt, new_tmo;
        bit  err_ev, done_ev;
        k   = classify(c);
        nxt = m_state;
        case (m_state)
            0: nxt = (k == 1) ? 1 : (k == 3) ? 3 : 0;
            1: nxt = (k == 2) ? 2 : (k == 3) ? 3 : (k == 0) ? 0 : 1;
            2: nxt = (k == 0) ? 0 : (k == 2) ? 2 : 3;
            default: nxt = (k == 0) ? 0 : 3;
        endcase
        err_ev  = (nxt == 3) && (m_state != 3);
        done_ev = (m_state == 2) && (k == 0);
        cyc++;
        if (nxt != m_state) entered = cyc;
        new_tmo = ((nxt == 1 || nxt == 2) && (cyc - entered >= TMO_CYC)) ? 1 : 0;
        m_irq   = (err_ev || (new_tmo == 1 && m_tmo == 0)) ? 1 : 0;
        m_tmo   = new_tmo;
        if (cl) begin
            m_done = 0; m_err = 0; m_sticky = 0;
        end
        if (done_ev && m_done < CMAX) m_done++;
        if (err_ev) begin
            if (m_err < CMAX) m_err++;
            m_sticky = 1;
        end
        m_state = nxt;
    endtask

    // Called at a falling edge: drive, advance one rising edge, check at the next falling edge.
    task automatic step(input logic [2:0] c, input logic cl = 1'b0);
        {o1, o2, err} = c;
        clr = cl;
        model_step(c, cl);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [2:0] c;
        int         r;
        int         len;
        cyc = 0;

        tag = "reset";
        model_reset();
        #7;
        check_all();
        @(negedge clk);
        nrst = 1'b1;

        tag = "normal_txn";
        step(3'b000); step(3'b100); step(3'b010); step(3'b000);

        tag = "error_from_armed";
        step(3'b100);
        repeat (5) step(3'b111);
        step(3'b000);

        tag = "illegal_in_idle";
        step(3'b110); step(3'b000);
        tag = "s1_in_busy";
        step(3'b100); step(3'b010); step(3'b100); step(3'b000);

        tag = "timeout";
        repeat (20) step(3'b100);
        repeat (3) step(3'b010);
        step(3'b000);

        tag = "saturation";
        step(3'b000, 1'b1);
        repeat (5) begin
            step(3'b000); step(3'b100); step(3'b010); step(3'b000);
        end
        tag = "clr_with_err";
        step(3'b111, 1'b1);
        step(3'b000);

        tag = "async_reset";
        step(3'b100); step(3'b010);
        #2 nrst = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        tag = "held_in_reset";
        check_all();
        nrst = 1'b1;
        tag = "after_reset";
        step(3'b100); step(3'b010); step(3'b000);

        tag = "random";
        repeat (80) begin
            r = $urandom_range(0, 9);
            if (r < 3)      c = 3'b000;
            else if (r < 6) c = 3'b100;
            else if (r < 8) c = 3'b010;
            else if (r < 9) c = 3'b111;
            else            c = 3'($urandom);
            len = $urandom_range(1, 20);
            repeat (len) step(c, ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
